arm_write_arbiter: RTL and testbench
====================================

ARM_WRITE_ARBITER -- requirements
Module: arm_write_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 10, width of the ARM instruction RAM address.
REQ-002 Parameter RAM_SIZE, default 1024, number of 32-bit words in the ARM instruction RAM; SHALL be no greater than 2**ADDRESS_WIDTH.
REQ-003 clk  input  1  sole clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-005 req0  input  1  translator (port 0) requests an append of word0 at the next sequential address.
REQ-006 word0  input  32  translator instruction word.
REQ-007 ack0  output  1  one-cycle pulse when the port-0 write completes or is refused.
REQ-008 req1  input  1  fixup/backpatch unit (port 1) requests an overwrite of word1 at addr1.
REQ-009 word1  input  32  patched instruction word.
REQ-010 addr1  input  ADDRESS_WIDTH  patch target address.
REQ-011 ack1  output  1  one-cycle pulse when the port-1 write completes or is refused.
REQ-012 start_write  output  1  one-cycle start pulse to the instruction RAM.
REQ-013 wr_word  output  32  word presented to the RAM; held stable from start_write until ready_arm.
REQ-014 wr_addr  output  ADDRESS_WIDTH  address presented to the RAM; held like wr_word.
REQ-015 ready_arm  input  1  RAM completion strobe; arrives 1 or more cycles after start_write.
REQ-016 emit_ptr  output  ADDRESS_WIDTH+1  count of words appended by port 0, which is also the next append address.
REQ-017 full  output  1  high while emit_ptr == RAM_SIZE.
REQ-018 err_overflow  output  1  sticky; set when a port-0 request is refused because the RAM is full.
REQ-019 err_patch  output  1  sticky; set when a port-1 request is refused because addr1 >= emit_ptr.

Function
REQ-020 States: IDLE, ISSUE, WAIT.
REQ-021 IDLE, no request pending: remain in IDLE with no outputs pulsed.
REQ-022 IDLE, exactly one request pending: grant that port.
REQ-023 IDLE, both requests pending: grant the port not served last; after reset, port 0 is treated as last served, so port 1 wins the first tie.
REQ-024 On grant, latch the word and the address into wr_word/wr_addr:
- port 0: address = emit_ptr;
- port 1: address = addr1;
- then go to ISSUE.
REQ-025 Refusal, port 0: a port-0 grant while full == 1 SHALL NOT write. It sets err_overflow, pulses ack0 in the next cycle, and returns to IDLE.
REQ-026 Refusal, port 1: a port-1 grant with addr1 >= emit_ptr SHALL NOT write. It sets err_patch, pulses ack1 in the next cycle, and returns to IDLE.
REQ-027 A refused grant still updates the last-served port.
REQ-028 ISSUE: assert start_write for exactly one cycle, then go to WAIT.
REQ-029 WAIT: hold wr_word/wr_addr stable and sample ready_arm each cycle. On the first cycle ready_arm == 1:
- pulse ack of the granted port in the following cycle;
- if port 0 was granted, increment emit_ptr in that same cycle;
- return to IDLE.
REQ-030 ready_arm is ignored outside WAIT.
REQ-031 Latency with ready_arm one cycle after start: req sampled in cycle N, start_write in N+1, ready_arm in N+2, ack in N+3. Back-to-back grants are no closer than 3 cycles.
REQ-032 Requesters hold req and data until their ack. Changes to data after the grant SHALL NOT affect the write in flight.
REQ-033 At most one write is in flight. start_write SHALL NOT pulse again before ready_arm for the previous write.
REQ-034 ack0 and ack1 SHALL never be high in the same cycle.
REQ-035 A port-1 write does not change emit_ptr. Patching address emit_ptr-1 is legal.
REQ-036 emit_ptr SHALL never exceed RAM_SIZE and SHALL NOT wrap.

Reset
REQ-037 reset low asynchronously forces:
- state IDLE;
- start_write, ack0, ack1, wr_word, wr_addr, emit_ptr, full, err_overflow and err_patch all 0;
- last-served = port 0.
REQ-038 Reset asserted mid-transaction abandons the write. No ack is issued for it, and a later ready_arm is ignored.
REQ-039 The first grant is possible on the first posedge after reset is released.

Verification
REQ-040 Single append: req0, word0=0xE3A01005, ready_arm 1 cycle after start -> start_write with wr_addr=0, wr_word=0xE3A01005; ack0 at N+3; emit_ptr=1.
REQ-041 Tie, alternating: req0 and req1 held (addr1=0 after one prior append) -> grant order 1,0,1,0; acks never coincide.
REQ-042 Slow RAM: ready_arm delayed 5 cycles -> wr_word/wr_addr stable throughout; single start_write pulse; ack 1 cycle after ready_arm.
REQ-043 Full: RAM_SIZE=4, 5 appends -> full=1 after the 4th; the 5th gets ack0 with no start_write; err_overflow=1; emit_ptr=4.
REQ-044 Bad patch: emit_ptr=2, req1 with addr1=2 -> no start_write; ack1 pulsed; err_patch=1; emit_ptr unchanged.
REQ-045 Reset in WAIT: reset low during WAIT, then ready_arm -> all outputs 0; no ack; emit_ptr=0.

Source files
------------

// File: rtl/arm_write_arbiter_if.sv
// Bus between the two instruction-word producers, the arbiter and the ARM
// instruction RAM write port. The arbiter connects through the slave modport;
// the requesters and RAM side connect through the master modport.
`timescale 1ns/1ps

interface arm_write_arbiter_if #(
    parameter int ADDRESS_WIDTH = 10
);
    // Port 0: translator appends at the next sequential address
    logic                     req0;
    logic [31:0]              word0;
    logic                     ack0;
    // Port 1: fixup/backpatch overwrites an already-emitted word
    logic                     req1;
    logic [31:0]              word1;
    logic [ADDRESS_WIDTH-1:0] addr1;
    logic                     ack1;
    // RAM write handshake
    logic                     start_write;
    logic [31:0]              wr_word;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic                     ready_arm;
    // Status
    logic [ADDRESS_WIDTH:0]   emit_ptr;
    logic                     full;
    logic                     err_overflow;
    logic                     err_patch;

    modport slave (
        input  req0, word0, req1, word1, addr1, ready_arm,
        output ack0, ack1, start_write, wr_word, wr_addr,
               emit_ptr, full, err_overflow, err_patch
    );

    modport master (
        output req0, word0, req1, word1, addr1, ready_arm,
        input  ack0, ack1, start_write, wr_word, wr_addr,
               emit_ptr, full, err_overflow, err_patch
    );
endinterface

// File: rtl/arm_write_arbiter.sv
// Two-port write arbiter in front of the ARM instruction RAM. Port 0 appends
// words at emit_ptr, port 1 patches words below emit_ptr. Ties alternate,
// one write is in flight at a time, and illegal requests are acknowledged
// without touching the RAM while raising a sticky error flag.
`timescale 1ns/1ps

module arm_write_arbiter #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int RAM_SIZE      = 1024
) (
    input  logic              clk,
    input  logic              reset,
    arm_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam logic [ADDRESS_WIDTH:0] RAM_WORDS = (ADDRESS_WIDTH + 1)'(RAM_SIZE);
    localparam logic [ADDRESS_WIDTH:0] PTR_ONE   = (ADDRESS_WIDTH + 1)'(1);

    state_e                   state_q, state_d;
    logic                     start_write_q, start_write_d;
    logic                     ack0_q, ack0_d;
    logic                     ack1_q, ack1_d;
    logic [31:0]              wr_word_q, wr_word_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDRESS_WIDTH:0]   emit_ptr_q, emit_ptr_d;
    logic                     err_overflow_q, err_overflow_d;
    logic                     err_patch_q, err_patch_d;
    // 1 = port 1 was granted last; also identifies the port of the write in flight
    logic                     last_port_q, last_port_d;

    logic full_w;
    logic grant0, grant1, refuse;

    assign full_w = (emit_ptr_q == RAM_WORDS);

    // Arbitration: a lone request wins; a tie goes to the port not served last
    always_comb begin
        grant1 = bus.req1 && (!bus.req0 || !last_port_q);
        grant0 = bus.req0 && !grant1;
        refuse = (grant0 && full_w) ||
                 (grant1 && ({1'b0, bus.addr1} >= emit_ptr_q));
    end

    // State and output register bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            start_write_q  <= 1'b0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            wr_word_q      <= '0;
            wr_addr_q      <= '0;
            emit_ptr_q     <= '0;
            err_overflow_q <= 1'b0;
            err_patch_q    <= 1'b0;
            last_port_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q        <= state_d;
            start_write_q  <= start_write_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            wr_word_q      <= wr_word_d;
            wr_addr_q      <= wr_addr_d;
            emit_ptr_q     <= emit_ptr_d;
            err_overflow_q <= err_overflow_d;
            err_patch_q    <= err_patch_d;
            last_port_q    <= last_port_d;
        end
    end

    // Next state: refused grants stay in IDLE, accepted ones run ISSUE -> WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if ((grant0 || grant1) && !refuse) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (bus.ready_arm) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next output values: registered pulses, latched write beat, pointer and error flags
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        start_write_d  = 1'b0;
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;
        wr_word_d      = wr_word_q;
        wr_addr_d      = wr_addr_q;
        emit_ptr_d     = emit_ptr_q;
        err_overflow_d = err_overflow_q;
        err_patch_d    = err_patch_q;
        last_port_d    = last_port_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    last_port_d = grant1;
                    if (refuse) begin
                        ack0_d         = grant0;
                        ack1_d         = grant1;
                        err_overflow_d = err_overflow_q | grant0;
                        err_patch_d    = err_patch_q | grant1;
                    end else begin
                        // Latch the beat now so later requester changes cannot reach the RAM
                        start_write_d = 1'b1;
                        wr_word_d     = grant1 ? bus.word1 : bus.word0;
                        wr_addr_d     = grant1 ? bus.addr1 : emit_ptr_q[ADDRESS_WIDTH-1:0];
                    end
                end
            end
            WAIT: begin
                if (bus.ready_arm) begin
                    ack0_d = !last_port_q;
                    ack1_d = last_port_q;
                    if (!last_port_q) emit_ptr_d = emit_ptr_q + PTR_ONE;
                end
            end
            default: ;
        endcase
    end

    assign bus.start_write  = start_write_q;
    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.wr_word      = wr_word_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.emit_ptr     = emit_ptr_q;
    assign bus.full         = full_w;
    assign bus.err_overflow = err_overflow_q;
    assign bus.err_patch    = err_patch_q;

endmodule

// File: tb/tb_arm_write_arbiter.sv
// Self-checking bench for arm_write_arbiter: directed vector table, a reset
// during WAIT, then random requester/RAM traffic against a transaction-level
// model of the arbitration rules.
`timescale 1ns/1ps

module tb_arm_write_arbiter;

    localparam int AW = 3;
    localparam int RS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arm_write_arbiter_if #(.ADDRESS_WIDTH(AW)) bus ();

    arm_write_arbiter #(.ADDRESS_WIDTH(AW), .RAM_SIZE(RS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // RAM image written by the bench's RAM from the DUT's write beats, and the
    // image the transaction expectations say it should hold
    logic [31:0] tb_ram  [2**AW];
    logic [31:0] exp_mem [2**AW];

    // Transaction-level model
    logic [AW:0] m_ptr;
    bit          m_last;
    bit          m_ovf;
    bit          m_pat;

    typedef struct {
        bit          r0;
        bit          r1;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [AW-1:0] a1;
        int          dly;
        bit          port;
        bit          refuse;
        logic [AW-1:0] addr;
        logic [31:0] word;
        logic [AW:0] ptr;
        bit          ovf;
        bit          pat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.req0      = 1'b0;
        bus.word0     = '0;
        bus.req1      = 1'b0;
        bus.word1     = '0;
        bus.addr1     = '0;
        bus.ready_arm = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, bus.start_write, 0);
        check({tag, "_ack0"}, bus.ack0, 0);
        check({tag, "_ack1"}, bus.ack1, 0);
        check({tag, "_wr_word"}, bus.wr_word, 0);
        check({tag, "_wr_addr"}, bus.wr_addr, 0);
        check({tag, "_emit_ptr"}, bus.emit_ptr, 0);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_err_ovf"}, bus.err_overflow, 0);
        check({tag, "_err_pat"}, bus.err_patch, 0);
    endtask

    task automatic model_reset();
        m_ptr  = '0;
        m_last = 1'b0;
        m_ovf  = 1'b0;
        m_pat  = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        model_reset();
    endtask

    // One arbitration round. Requests are already driven; the grant happens on
    // the next posedge. The bench plays the RAM with ready_arm dly cycles after
    // start_write, and the granted requester drops its req on its ack.
    task automatic do_txn(input bit port, input bit refuse, input logic [AW-1:0] addr,
                          input logic [31:0] word, input int dly, input logic [AW:0] ptr,
                          input bit ovf, input bit pat);
        @(posedge clk);
        @(negedge clk);
        if (refuse) begin
            check("refuse_no_start", bus.start_write, 0);
            check("refuse_ack0", bus.ack0, !port);
            check("refuse_ack1", bus.ack1, port);
        end else begin
            check("start_write", bus.start_write, 1);
            check("issue_no_ack", {bus.ack0, bus.ack1}, 0);
            check("issue_addr", bus.wr_addr, addr);
            check("issue_word", bus.wr_word, word);
            // Scramble the granted requester's data; the write in flight must not change
            if (port) begin
                bus.word1 = ~word;
                bus.addr1 = ~addr;
            end else begin
                bus.word0 = ~word;
            end
            for (int k = 1; k <= dly; k++) begin
                @(posedge clk);
                @(negedge clk);
                check("wait_no_start", bus.start_write, 0);
                check("wait_no_ack", {bus.ack0, bus.ack1}, 0);
                check("hold_addr", bus.wr_addr, addr);
                check("hold_word", bus.wr_word, word);
                if (k == dly) begin
                    bus.ready_arm = 1'b1;
                    tb_ram[bus.wr_addr] = bus.wr_word;
                end
            end
            @(posedge clk);
            @(negedge clk);
            bus.ready_arm = 1'b0;
            check("done_no_start", bus.start_write, 0);
            check("done_ack0", bus.ack0, !port);
            check("done_ack1", bus.ack1, port);
            exp_mem[addr] = word;
        end
        check("emit_ptr", bus.emit_ptr, ptr);
        check("full", bus.full, ptr == RS);
        check("err_overflow", bus.err_overflow, ovf);
        check("err_patch", bus.err_patch, pat);
        if (port) bus.req1 = 1'b0;
        else      bus.req0 = 1'b0;
    endtask

    task automatic compare_ram(input string tag);
        for (int i = 0; i < 2**AW; i++) begin
            check({tag, "_ram"}, tb_ram[i], exp_mem[i]);
        end
    endtask

    initial begin
        bit          p0, p1;
        logic [31:0] w0, w1;
        logic [AW-1:0] a1;
        bit          port, refuse;
        logic [AW-1:0] addr;
        logic [31:0] word;

        for (int i = 0; i < 2**AW; i++) begin
            tb_ram[i]  = '0;
            exp_mem[i] = '0;
        end

        //          r0 r1  w0            w1            a1    dly port ref addr  word          ptr   ovf pat
        vecs[0]  = '{1, 0, 32'hE3A01005, 32'h0,        3'd0, 1,  0,   0,  3'd0, 32'hE3A01005, 4'd1, 0,  0};
        vecs[1]  = '{1, 1, 32'h11110000, 32'h22220000, 3'd0, 2,  1,   0,  3'd0, 32'h22220000, 4'd1, 0,  0};
        vecs[2]  = '{1, 1, 32'h11110000, 32'h22220001, 3'd0, 1,  0,   0,  3'd1, 32'h11110000, 4'd2, 0,  0};
        vecs[3]  = '{1, 1, 32'h11110002, 32'h22220001, 3'd0, 1,  1,   0,  3'd0, 32'h22220001, 4'd2, 0,  0};
        vecs[4]  = '{1, 1, 32'h11110002, 32'h22220003, 3'd0, 1,  0,   0,  3'd2, 32'h11110002, 4'd3, 0,  0};
        vecs[5]  = '{0, 1, 32'h0,        32'h22220003, 3'd0, 1,  1,   0,  3'd0, 32'h22220003, 4'd3, 0,  0};
        vecs[6]  = '{0, 1, 32'h0,        32'hBAD00003, 3'd3, 1,  1,   1,  3'd3, 32'hBAD00003, 4'd3, 0,  1};
        vecs[7]  = '{0, 1, 32'h0,        32'h33330002, 3'd2, 5,  1,   0,  3'd2, 32'h33330002, 4'd3, 0,  1};
        vecs[8]  = '{1, 0, 32'h44440003, 32'h0,        3'd0, 3,  0,   0,  3'd3, 32'h44440003, 4'd4, 0,  1};
        vecs[9]  = '{1, 0, 32'h55550004, 32'h0,        3'd0, 1,  0,   1,  3'd4, 32'h55550004, 4'd4, 1,  1};
        vecs[10] = '{0, 1, 32'h0,        32'h66660003, 3'd3, 1,  1,   0,  3'd3, 32'h66660003, 4'd4, 1,  1};

        apply_reset();

        // Directed table: single append, 1/0/1/0 tie alternation, bad patch,
        // slow RAM, fill to full, overflow refusal, patch at emit_ptr-1 while full
        for (int i = 0; i < 11; i++) begin
            bus.req0  = vecs[i].r0;
            bus.word0 = vecs[i].w0;
            bus.req1  = vecs[i].r1;
            bus.word1 = vecs[i].w1;
            bus.addr1 = vecs[i].a1;
            do_txn(vecs[i].port, vecs[i].refuse, vecs[i].addr, vecs[i].word, vecs[i].dly,
                   vecs[i].ptr, vecs[i].ovf, vecs[i].pat);
        end
        compare_ram("table");

        // Reset while a write waits for the RAM: no ack, late ready_arm ignored
        apply_reset();
        bus.req0  = 1'b1;
        bus.word0 = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        check("rw_start", bus.start_write, 1);
        @(posedge clk);
        @(negedge clk);
        check("rw_in_wait", bus.start_write, 0);
        #2;
        reset    = 1'b0;
        bus.req0 = 1'b0;
        #1;
        check_reset_outputs("rst_in_wait");
        @(negedge clk);
        reset         = 1'b1;
        bus.ready_arm = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ready_arm = 1'b0;
        check("rw_no_ack", {bus.ack0, bus.ack1}, 0);
        check("rw_no_start", bus.start_write, 0);
        check("rw_emit_ptr", bus.emit_ptr, 0);
        @(posedge clk);
        @(negedge clk);
        check("rw_still_quiet", {bus.ack0, bus.ack1, bus.start_write}, 0);
        model_reset();

        // Random traffic against the transaction model
        apply_reset();
        p0 = 1'b0;
        p1 = 1'b0;
        w0 = '0;
        w1 = '0;
        a1 = '0;
        for (int r = 0; r < 300; r++) begin
            if (r % 60 == 59) apply_reset();
            if (!p0 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1;
                w0 = $urandom;
            end
            if (!p1 && $urandom_range(0, 2) == 0) begin
                p1 = 1'b1;
                w1 = $urandom;
                a1 = AW'($urandom_range(0, 5));
            end
            bus.req0  = p0;
            bus.word0 = w0;
            bus.req1  = p1;
            bus.word1 = w1;
            bus.addr1 = a1;
            if (!p0 && !p1) begin
                // Stray ready_arm while idle must be ignored
                bus.ready_arm = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                bus.ready_arm = 1'b0;
                check("idle_no_start", bus.start_write, 0);
                check("idle_no_ack", {bus.ack0, bus.ack1}, 0);
                check("idle_emit_ptr", bus.emit_ptr, m_ptr);
            end else begin
                port = p1 && (!p0 || !m_last);
                if (port) begin
                    refuse = ({1'b0, a1} >= m_ptr);
                    addr   = a1;
                    word   = w1;
                end else begin
                    refuse = (m_ptr == RS);
                    addr   = m_ptr[AW-1:0];
                    word   = w0;
                end
                m_last = port;
                if (refuse) begin
                    if (port) m_pat = 1'b1;
                    else      m_ovf = 1'b1;
                end else if (!port) begin
                    m_ptr = m_ptr + 1'b1;
                end
                do_txn(port, refuse, addr, word, $urandom_range(1, 4), m_ptr, m_ovf, m_pat);
                if (port) p1 = 1'b0;
                else      p0 = 1'b0;
            end
        end
        compare_ram("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
